// File: rtl/sevenseg_pkg.sv
// Shared types, constants and nibble selection for the seven-segment scan controller.
package sevenseg_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

    localparam logic [6:0] SEG_OFF_N  = 7'h7F;
    localparam int         MAX_DIGITS = 16;

    function automatic logic [3:0] nibble_sel(input logic [4*MAX_DIGITS-1:0] value,
                                              input logic [3:0]              idx);
        logic [5:0] base;
        base = {idx, 2'b00};
        return value[base +: 4];
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_decoder.sv
// Hex nibble to active-low gfedcba segment pattern; purely combinational.
module sevenseg (
    input  logic [3:0] hex,
    output logic [6:0] hexn
);

    always_comb begin
        hexn = 7'h7F;
        case (hex)
            4'h0: hexn = ~7'h3F;
            4'h1: hexn = ~7'h06;
            4'h2: hexn = ~7'h5B;
            4'h3: hexn = ~7'h4F;
            4'h4: hexn = ~7'h66;
            4'h5: hexn = ~7'h6D;
            4'h6: hexn = ~7'h7D;
            4'h7: hexn = ~7'h07;
            4'h8: hexn = ~7'h7F;
            4'h9: hexn = ~7'h6F;
            4'hA: hexn = ~7'h77;
            4'hB: hexn = ~7'h7C;
            4'hC: hexn = ~7'h39;
            4'hD: hexn = ~7'h5E;
            4'hE: hexn = ~7'h79;
            4'hF: hexn = ~7'h71;
            default: hexn = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Scans NUM_DIGITS digits, one REFRESH_DIV slot each with a BLANK_CYCLES dark lead-in; value/dp are
// snapshotted once per frame. Outputs lag state by one cycle. `define LEADING_ZERO_SUPPRESS_EN darkens leading zeros.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int PW   = $clog2(REFRESH_DIV);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int EXTW = 4 * MAX_DIGITS;

    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
        $error("sevenseg_scan_ctrl: NUM_DIGITS must be in 2..16");
    end
    if (REFRESH_DIV < 4) begin : g_bad_refresh_div
        $error("sevenseg_scan_ctrl: REFRESH_DIV must be >= 4");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
        $error("sevenseg_scan_ctrl: BLANK_CYCLES must be in 1..REFRESH_DIV-1");
    end

    scan_state_t             state_q, state_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    tick_q, tick_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [3:0]              cur_nibble;
    logic [6:0]              dec_hexn;
    logic                    digit_lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            idx_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            tick_q     <= 1'b0;
            seg_q      <= SEG_OFF_N;
            dp_n_q     <= 1'b1;
            an_q       <= '1;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            tick_q     <= tick_d;
            seg_q      <= seg_d;
            dp_n_q     <= dp_n_d;
            an_q       <= an_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        tick_d     = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            pre_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = BLANK;
                    pre_d      = '0;
                    idx_d      = '0;
                    snap_val_d = value;
                    snap_dp_d  = dp;
                    tick_d     = 1'b1;
                end
                BLANK: begin
                    pre_d = pre_q + 1'b1;
                    if (pre_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (pre_q == PRE_LAST) begin
                        pre_d   = '0;
                        state_d = BLANK;
                        // Wrapping back to digit 0 is the only point where new data is admitted.
                        if (idx_q == IDX_LAST) begin
                            idx_d      = '0;
                            snap_val_d = value;
                            snap_dp_d  = dp;
                            tick_d     = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cur_nibble = nibble_sel(EXTW'(snap_val_q), 4'(idx_q));

    sevenseg u_dec (
        .hex  (cur_nibble),
        .hexn (dec_hexn)
    );

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic upper_zero;

    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_q) && snap_val_q[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        digit_lit = (idx_q == '0) || !upper_zero;
    end
`else
    assign digit_lit = 1'b1;
`endif

    // Segments are loaded during BLANK too, so they are settled before the anode turns on.
    always_comb begin
        seg_d  = SEG_OFF_N;
        dp_n_d = 1'b1;
        an_d   = '1;
        if (enable) begin
            case (state_q)
                BLANK: seg_d = digit_lit ? dec_hexn : SEG_OFF_N;
                SHOW: begin
                    seg_d       = digit_lit ? dec_hexn : SEG_OFF_N;
                    dp_n_d      = ~snap_dp_q[idx_q];
                    an_d[idx_q] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios plus randomized traffic against a scan-time reference model.
module tb_sevenseg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;
`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .dp         (dp),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = v >> (4 * d);
        nib   = upper[3:0];
        if (LZS && d > 0 && upper == 16'h0) return 7'h7F;
        return ~seg_on[nib];
    endfunction

    // Reference: m_c counts cycles since the scan started; slot/phase follow from plain division.
    bit          m_run = 1'b0;
    int          m_c = 0;
    int          m_ph, m_dg;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [6:0]  m_seg = 7'h7F;
    logic        m_dp_n = 1'b1;
    logic [3:0]  m_an = 4'hF;
    logic        m_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        m_seg  = 7'h7F;
        m_dp_n = 1'b1;
        m_an   = 4'hF;
        m_tick = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0;
            m_c   = 0;
            m_val = 16'h0;
            m_dp  = 4'h0;
        end else if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_c    = 0;
            m_val  = value;
            m_dp   = dp;
            m_tick = 1'b1;
        end else begin
            m_ph  = m_c % RD;
            m_dg  = (m_c / RD) % ND;
            m_seg = exp_seg(m_val, m_dg);
            if (m_ph >= BC) begin
                m_an   = ~(4'b0001 << m_dg);
                m_dp_n = ~m_dp[m_dg];
            end
            m_c = m_c + 1;
            if (m_c % FRAME == 0) begin
                m_val  = value;
                m_dp   = dp;
                m_tick = 1'b1;
            end
        end
    end

    task automatic wait_slot(input int d, input int min_ph, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_run && ((m_c % FRAME) / RD) == d && (m_c % RD) >= min_ph) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_tick) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL reset_dark: got seg=%h dp_n=%b an=%b tick=%b, want 7f 1 1111 0", seg_n, dp_n, an_n, frame_tick);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL idle_dark: got seg=%h dp_n=%b an=%b tick=%b, want 7f 1 1111 0", seg_n, dp_n, an_n, frame_tick);
        else n_pass++;
    endtask

    // Digit 0 carries nibble 0, i.e. the '4' of 16'h1234.
    task automatic test_scan_basic();
        logic [3:0] want_an;
        logic [6:0] want_seg;
        value  = 16'h1234;
        dp     = 4'h0;
        enable = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            want_an  = 4'hF;
            want_seg = 7'h7F;
            if (i >= 3 && i <= 8)        begin want_an = 4'b1110; want_seg = ~7'h66; end
            else if (i >= 11 && i <= 16) begin want_an = 4'b1101; want_seg = ~7'h4F; end
            else if (i >= 19 && i <= 24) begin want_an = 4'b1011; want_seg = ~7'h5B; end
            else if (i >= 27 && i <= 32) begin want_an = 4'b0111; want_seg = ~7'h06; end
            n_checks++;
            if (an_n !== want_an) $display("FAIL basic_an i=%0d: got %b want %b", i, an_n, want_an);
            else n_pass++;
            n_checks++;
            if (frame_tick !== (i == 0 || i == FRAME)) $display("FAIL basic_tick i=%0d: got %b", i, frame_tick);
            else n_pass++;
            if (want_an != 4'hF) begin
                n_checks++;
                if (seg_n !== want_seg) $display("FAIL basic_seg i=%0d: got %h want %h", i, seg_n, want_seg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        bit seen;
        wait_slot(2, 0, ok);
        n_checks++;
        if (!ok) $display("FAIL snap_wait: digit 2 slot not reached within budget");
        else n_pass++;
        value = 16'hABCD;
        seen  = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            n_checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {m_seg, m_dp_n, m_an, m_tick})
                $display("FAIL snap_model i=%0d: got %h %b %b %b want %h %b %b %b", i, seg_n, dp_n, an_n, frame_tick, m_seg, m_dp_n, m_an, m_tick);
            else n_pass++;
            if (!seen && (an_n == 4'b1011 || an_n == 4'b0111)) begin
                n_checks++;
                if (seg_n !== (an_n == 4'b1011 ? ~7'h5B : ~7'h06)) $display("FAIL snap_old an=%b: got %h", an_n, seg_n);
                else n_pass++;
            end
            if (seen && (an_n == 4'b1110 || an_n == 4'b1101)) begin
                n_checks++;
                if (seg_n !== (an_n == 4'b1110 ? ~7'h5E : ~7'h39)) $display("FAIL snap_new an=%b: got %h", an_n, seg_n);
                else n_pass++;
            end
            if (frame_tick) seen = 1'b1;
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        wait_slot(2, BC + 1, ok);
        n_checks++;
        if (!ok) $display("FAIL drop_wait: digit 2 SHOW not reached within budget");
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL drop_dark: got seg=%h dp_n=%b an=%b tick=%b", seg_n, dp_n, an_n, frame_tick);
        else n_pass++;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if ({frame_tick, an_n} !== {1'b1, 4'hF}) $display("FAIL drop_restart: got tick=%b an=%b", frame_tick, an_n);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (an_n !== 4'b1110) $display("FAIL drop_digit0: got an=%b want 1110", an_n);
                else n_pass++;
            end
            n_checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {m_seg, m_dp_n, m_an, m_tick})
                $display("FAIL drop_model i=%0d: got %h %b %b %b want %h %b %b %b", i, seg_n, dp_n, an_n, frame_tick, m_seg, m_dp_n, m_an, m_tick);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_slot(1, BC + 2, ok);
        n_checks++;
        if (!ok) $display("FAIL arst_wait: SHOW not reached within budget");
        else n_pass++;
        n_checks++;
        if (an_n !== 4'b1101) $display("FAIL arst_lit: got an=%b want 1101", an_n);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL arst_dark: got seg=%h dp_n=%b an=%b tick=%b", seg_n, dp_n, an_n, frame_tick);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (frame_tick !== 1'b1) $display("FAIL arst_restart: got tick=%b want 1", frame_tick);
                else n_pass++;
            end
            n_checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {m_seg, m_dp_n, m_an, m_tick})
                $display("FAIL arst_model i=%0d: got %h %b %b %b want %h %b %b %b", i, seg_n, dp_n, an_n, frame_tick, m_seg, m_dp_n, m_an, m_tick);
            else n_pass++;
        end
    endtask

    task automatic test_dp();
        bit ok;
        dp = 4'b0100;
        wait_tick(ok);
        n_checks++;
        if (!ok) $display("FAIL dp_wait: no frame start within budget");
        else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if ((dp_n == 1'b0) !== (an_n == 4'b1011)) $display("FAIL dp_only_digit2 i=%0d: got dp_n=%b an=%b", i, dp_n, an_n);
            else n_pass++;
            n_checks++;
            if ($countones(~an_n) > 1) $display("FAIL dp_onehot i=%0d: got an=%b", i, an_n);
            else n_pass++;
        end
        dp = 4'h0;
    endtask

    task automatic test_leading_zero();
        bit         ok;
        logic [6:0] want;
        logic [15:0] pats [2] = '{16'h0040, 16'h0000};
        for (int p = 0; p < 2; p++) begin
            value = pats[p];
            wait_tick(ok);
            n_checks++;
            if (!ok) $display("FAIL lzs_wait: no frame start within budget");
            else n_pass++;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                want = LZS ? 7'h7F : ~7'h3F;
                if (an_n == 4'b1110) want = ~7'h3F;
                if (an_n == 4'b1101 && pats[p] == 16'h0040) want = ~7'h66;
                if (an_n != 4'hF) begin
                    n_checks++;
                    if (seg_n !== want) $display("FAIL lzs_seg v=%h an=%b: got %h want %h", pats[p], an_n, seg_n, want);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            n_checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {m_seg, m_dp_n, m_an, m_tick})
                $display("FAIL rand_model i=%0d: got %h %b %b %b want %h %b %b %b", i, seg_n, dp_n, an_n, frame_tick, m_seg, m_dp_n, m_an, m_tick);
            else n_pass++;
            n_checks++;
            if ($countones(~an_n) > 1) $display("FAIL rand_onehot i=%0d: got an=%b", i, an_n);
            else n_pass++;
            if ($urandom_range(0, 15) == 0) value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_snapshot();
        test_enable_drop();
        test_async_reset();
        test_dp();
        test_leading_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
